fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Instruction-fetch PC generator for the RISC-V core. It is the consumer side of branch resolution: it holds the architectural fetch PC, issues one instruction-memory request at a time, and presents each fetched instruction with its PC to decode. It redirects to `redirect_pc` whenever the branch/jump unit resolves a taken branch, and discards any stale in-flight fetch.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `redirect_valid` input 1: taken branch or jump resolved this cycle.
- `redirect_pc` input 32: target address. Sampled only when `redirect_valid` is high.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output 32: fetch address, equal to the current `pc`.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_rsp_valid` input 1: response valid. Exactly one response per accepted request, arriving at least 1 cycle later.
- `imem_rsp_data` input 32: fetched instruction word.
- `instr_valid` output 1: instruction available to decode.
- `instr_pc` output 32: PC of the presented instruction.
- `instr_code` output 32: presented instruction word.
- `instr_ready` input 1: decode accepts the instruction.
- `fetch_fault` output 1: misaligned redirect fault (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- Registers: `pc`, `kill`, `instr_pc_q`, `instr_code_q`.
- Reset values:
  - state = IDLE, `pc` = RESET_PC, `kill` = 0.
  - All outputs 0, except `imem_req_addr` = RESET_PC.
- IDLE → REQ unconditionally on the next cycle.
- REQ: `imem_req_valid` = 1.
  - On `imem_req_ready` → WAIT.
  - Otherwise hold, keeping the address stable.
- WAIT: on `imem_rsp_valid`:
  - If `kill` = 0: capture data and `pc` into `instr_code_q` and `instr_pc_q` → HOLD.
  - If `kill` = 1: drop the data, clear `kill` → REQ.
- HOLD: `instr_valid` = 1.
  - On `instr_ready`: `pc` ← `pc` + 4 (mod 2^32, wraps to 0) → REQ.
- Redirect has priority over every other transition in all states. It sets `pc` ← `redirect_pc`, plus the per-state action below:
  - IDLE or REQ without handshake: → REQ.
  - REQ with `imem_req_ready` in the same cycle: the request for the old `pc` is accepted. Set `kill` = 1 → WAIT.
  - WAIT with no response this cycle: `kill` ← 1, stay in WAIT.
  - WAIT with response in the same cycle: drop the response → REQ.
  - HOLD: drop the held instruction, even if `instr_ready` is high in the same cycle. No `pc` + 4 → REQ.
  - FAULT: → REQ if the target is aligned.
- Back-to-back redirects: the last one wins. `kill` stays set until the single outstanding response returns.
- At most one request is ever outstanding.

## Timing
- `imem_req_valid` and `instr_valid` are decoded from registered state only. No combinational path from any input to any output.
- First request: cycle 2 after the first edge with `rst_n` = 1.
- Minimum instruction period, with ready and a 1-cycle memory: 3 cycles (REQ → WAIT → HOLD).
- Redirect to new request: the request for `redirect_pc` is valid 1 cycle after `redirect_valid`. If a request was outstanding, it issues 1 cycle after the killed response returns.
- `rst_n` low mid-transaction: the next edge forces the reset values. A response to a pre-reset request is not expected; memory is reset in the same cycle.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 enters FAULT. `fetch_fault` = 1 from the next cycle.
  - No requests are issued in FAULT. Only an aligned redirect leaves it.
  - An outstanding response is still drained (`kill` set) before FAULT takes effect.
- Not defined:
  - `redirect_pc[1:0]` is forced to `2'b00`.
  - `fetch_fault` is tied 0 and FAULT is unreachable.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE, REQ, WAIT, HOLD, FAULT),
  - `PC_W` = 32,
  - `PC_INC` = 4,
  - default `RESET_PC`.
- Sub-module `fetch_pc_reg`: the `pc` register plus the next-PC mux (hold / +4 / redirect), including the alignment masking. The top level holds the state machine, `kill`, and the output registers.

## Test plan
- Reset with RESET_PC = `32'h100`, memory always ready with 1-cycle latency, decode always ready → requests at `0x100`, `0x104`, `0x108`, one every 3 cycles. `instr_pc` matches each address.
- Redirect to `0x400` while in WAIT, response returns 2 cycles later → that response is dropped, the next request is at `0x400`, and `instr_valid` never shows the stale word.
- `instr_ready` held low for 5 cycles in HOLD → `instr_valid`, `instr_pc` and `instr_code` stay stable, with no new request. `instr_ready` high then redirect to `0x200` in the same cycle → the held instruction is dropped and the next request is at `0x200`.
- `imem_req_ready` low for 4 cycles → `imem_req_addr` stays constant. A redirect in the cycle ready rises → WAIT with kill set, then a request at the redirect target.
- `pc` = `0xFFFF_FFFC`, instruction accepted → the next request is at `0x0000_0000`.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to `0x302` → `fetch_fault` = 1 and no requests. Then redirect to `0x300` → fault clears and a request issues at `0x300`. Without the macro, the same redirect fetches `0x300`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
package fetch_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StFault
    } fetch_state_e;

    typedef enum logic [1:0] {
        PcHold,
        PcInc,
        PcRedirect
    } pc_sel_e;

    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch bus bundle: redirect input, instruction-memory request/response and decode port.
interface fetch_pc_gen_if;
    import fetch_pkg::*;

    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [PC_W-1:0] imem_rsp_data;
    logic            instr_valid;
    logic [PC_W-1:0] instr_pc;
    logic [PC_W-1:0] instr_code;
    logic            instr_ready;
    logic            fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_code, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_code, fetch_fault
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Architectural fetch PC register with hold / +4 / redirect next-PC mux.
// FETCH_MISALIGN_CHECK_EN keeps redirect_pc[1:0]; otherwise the low bits are forced to zero.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         sel_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = redirect_pc_i;
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc_i[1:0];
    assign target     = {redirect_pc_i[PC_W-1:2], 2'b00};
`endif

    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PcInc:      pc_d = pc_q + PC_INC;
            PcRedirect: pc_d = target;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one outstanding imem request, redirect with stale-response kill.
// FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect FAULT state and fetch_fault output.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input logic            clk,
    input logic            rst_n,
    fetch_pc_gen_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic [PC_W-1:0] instr_code_q, instr_code_d;
    pc_sel_e         pc_sel;
    logic [PC_W-1:0] pc;
    fetch_state_e    redir_st, drain_st;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_i        (pc_sel),
        .redirect_pc_i(bus.redirect_pc),
        .pc_o         (pc)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    // A killed response must drain first; the pc then decides between FAULT and REQ.
    assign redir_st        = pc_misaligned(bus.redirect_pc) ? StFault : StReq;
    assign drain_st        = pc_misaligned(pc) ? StFault : StReq;
    assign bus.fetch_fault = (state_q == StFault);
`else
    assign redir_st        = StReq;
    assign drain_st        = StReq;
    assign bus.fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        instr_pc_d   = instr_pc_q;
        instr_code_d = instr_code_q;
        pc_sel       = PcHold;

        if (bus.redirect_valid) begin
            pc_sel = PcRedirect;
            unique case (state_q)
                StReq: begin
                    if (bus.imem_req_ready) begin
                        kill_d  = 1'b1;
                        state_d = StWait;
                    end else begin
                        state_d = redir_st;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = redir_st;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = redir_st;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (bus.imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = drain_st;
                        end else begin
                            instr_pc_d   = pc;
                            instr_code_d = bus.imem_rsp_data;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.instr_ready) begin
                        pc_sel  = PcInc;
                        state_d = StReq;
                    end
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            kill_q       <= 1'b0;
            instr_pc_q   <= '0;
            instr_code_q <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            instr_pc_q   <= instr_pc_d;
            instr_code_q <= instr_code_d;
        end
    end

    assign bus.imem_req_valid = (state_q == StReq);
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = (state_q == StHold);
    assign bus.instr_pc       = instr_pc_q;
    assign bus.instr_code     = instr_code_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus randomized traffic vs a flag model.
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lat = 1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Model: live = left idle, busy = request outstanding, stale = its response is dropped.
    logic        m_live, m_busy, m_stale, m_held, m_fault;
    logic [31:0] m_pc, m_ipc, m_icode;

    fetch_pc_gen_if bus ();

    fetch_pc_gen #(
        .RESET_PC(RPC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    function automatic logic misal(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_live  = 1'b0;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_held  = 1'b0;
        m_fault = 1'b0;
        m_pc    = RPC;
        m_ipc   = '0;
        m_icode = '0;
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = '0;
        bus.instr_ready      = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_req_addr", bus.imem_req_addr, RPC);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_instr_code", bus.instr_code, 32'h0);
        check("rst_fault", bus.fetch_fault, 1'b0);
        model_reset();
        cyc   = 0;
        rst_n = 1'b1;
    endtask

    // Drive one cycle, compare the DUT against the model, advance the model and the clock.
    task automatic cyc_step(input bit rv, input logic [31:0] rpc, input bit irdy, input bit mrdy);
        bit          rsp;
        logic [31:0] rdata;
        bit          m_req, acc, got;
        logic [31:0] tgt;
        rsp   = 1'b0;
        rdata = '0;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            rsp   = 1'b1;
            rdata = memword(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = irdy;
        bus.imem_req_ready = mrdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rdata;

        m_req = m_live && !m_busy && !m_held && !m_fault;
        check("req_valid", bus.imem_req_valid, m_req);
        check("req_addr", bus.imem_req_addr, m_pc);
        check("instr_valid", bus.instr_valid, m_held);
        check("instr_pc", bus.instr_pc, m_ipc);
        check("instr_code", bus.instr_code, m_icode);
        check("fetch_fault", bus.fetch_fault, m_fault);

        if (bus.imem_req_valid && mrdy) begin
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(cyc + lat);
        end

        acc = m_req && mrdy;
        got = m_busy && rsp;
        tgt = eff_target(rpc);
        if (rv) begin
            m_pc   = tgt;
            m_held = 1'b0;
            m_live = 1'b1;
            if (acc) begin
                m_busy  = 1'b1;
                m_stale = 1'b1;
            end else if (m_busy && !rsp) begin
                m_stale = 1'b1;
            end else if (got) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            m_fault = !m_busy && misal(tgt);
`endif
        end else if (!m_live) begin
            m_live = 1'b1;
        end else if (acc) begin
            m_busy = 1'b1;
        end else if (got) begin
            m_busy = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                m_fault = misal(m_pc);
`endif
            end else begin
                m_held  = 1'b1;
                m_ipc   = m_pc;
                m_icode = memword(m_pc);
            end
        end else if (m_held && irdy) begin
            m_held = 1'b0;
            m_pc   = m_pc + 32'd4;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        do_reset();

        // Straight-line fetch from RESET_PC, one instruction every 3 cycles.
        lat = 1;
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t1_req0_valid", bus.imem_req_valid, 1'b1);
        check("t1_req0_addr", bus.imem_req_addr, 32'h0000_0100);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t1_hold_valid", bus.instr_valid, 1'b1);
        check("t1_hold_pc", bus.instr_pc, 32'h0000_0100);
        check("t1_hold_code", bus.instr_code, 32'hC0DE_0100);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t1_req1_addr", bus.imem_req_addr, 32'h0000_0104);
        check("t1_req1_valid", bus.imem_req_valid, 1'b1);
        repeat (3) cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t1_req2_addr", bus.imem_req_addr, 32'h0000_0108);

        // Redirect in WAIT; the stale response comes back two cycles later.
        lat = 3;
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        cyc_step(1'b1, 32'h0000_0400, 1'b1, 1'b1);
        check("t2_wait_noreq", bus.imem_req_valid, 1'b0);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t2_req_valid", bus.imem_req_valid, 1'b1);
        check("t2_req_addr", bus.imem_req_addr, 32'h0000_0400);
        check("t2_no_stale", bus.instr_valid, 1'b0);

        // Decode stalls in HOLD, then redirect together with instr_ready.
        lat = 1;
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", bus.instr_valid, 1'b1);
            check("t3_hold_pc", bus.instr_pc, 32'h0000_0400);
            check("t3_hold_code", bus.instr_code, 32'hC0DE_0400);
            check("t3_hold_noreq", bus.imem_req_valid, 1'b0);
            cyc_step(1'b0, '0, 1'b0, 1'b1);
        end
        cyc_step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        check("t3_drop_valid", bus.instr_valid, 1'b0);
        check("t3_req_addr", bus.imem_req_addr, 32'h0000_0200);

        // Memory not ready for 4 cycles, then redirect as ready rises.
        for (int i = 0; i < 4; i++) begin
            check("t4_stall_valid", bus.imem_req_valid, 1'b1);
            check("t4_stall_addr", bus.imem_req_addr, 32'h0000_0200);
            cyc_step(1'b0, '0, 1'b1, 1'b0);
        end
        cyc_step(1'b1, 32'h0000_0280, 1'b1, 1'b1);
        check("t4_kill_noreq", bus.imem_req_valid, 1'b0);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t4_req_valid", bus.imem_req_valid, 1'b1);
        check("t4_req_addr", bus.imem_req_addr, 32'h0000_0280);
        check("t4_no_stale", bus.instr_valid, 1'b0);

        // PC wrap from the top of the address space.
        cyc_step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("t5_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t5_hold_pc", bus.instr_pc, 32'hFFFF_FFFC);
        cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t5_wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // Misaligned redirect.
        cyc_step(1'b1, 32'h0000_0302, 1'b1, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_fault", bus.fetch_fault, 1'b1);
        check("t6_fault_noreq", bus.imem_req_valid, 1'b0);
        repeat (3) cyc_step(1'b0, '0, 1'b1, 1'b1);
        check("t6_fault_held", bus.fetch_fault, 1'b1);
        check("t6_fault_noreq2", bus.imem_req_valid, 1'b0);
        cyc_step(1'b1, 32'h0000_0300, 1'b1, 1'b0);
        check("t6_fault_clear", bus.fetch_fault, 1'b0);
`else
        check("t6_nofault", bus.fetch_fault, 1'b0);
`endif
        check("t6_req_valid", bus.imem_req_valid, 1'b1);
        check("t6_req_addr", bus.imem_req_addr, 32'h0000_0300);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 4000; i++) begin
            bit          rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc[31:4] = 28'hFFF_FFFF;
            lat = $urandom_range(1, 3);
            if (i == 1500 || i == 3000) begin
                do_reset();
            end else begin
                cyc_step(rv, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
